mem_stage: RTL and testbench

- Memory-access stage between the EX/MEM pipeline register and the MEM/WB register file write-back path.
- Consumes the registered EX/MEM outputs (control bits, ALU result, store data, destination register).
- Performs load/store through a req/ack data-memory port, stalling upstream until the access completes.
- Presents registered MEM/WB outputs to write-back.

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage between EX/MEM and MEM/WB
module mem_stage #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [DATA_W-1:0] Datain,
  input  logic [4:0]        Rd_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              valid_out,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic [DATA_W-1:0] AluOut,
  output logic [DATA_W-1:0] ReadData_Out,
  output logic [4:0]        Rd_out,
  output logic              mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state, nextState;
  logic [31:0] cnt;
  logic        latRegWrite, latMemtoReg;
  logic [4:0]  latRd;
  logic        memop, aligned, timeoutHit;

  assign memop      = valid_in & (MemtoReg | MemWrite);
  assign aligned    = (AluResult[2:0] == 3'b000);
  assign timeoutHit = (TIMEOUT != 0) && (state == ACCESS) && !mem_ack && (cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state and upstream stall; ack beats timeout in the same cycle
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (memop && aligned) begin
          nextState = ACCESS;
          stall     = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack || timeoutHit) nextState = IDLE;
        else                       stall     = 1'b1;
      end
      default: nextState = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // Memory port, latched instruction, timeout counter and MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      latRegWrite  <= 1'b0;
      latMemtoReg  <= 1'b0;
      latRd        <= '0;
      valid_out    <= 1'b0;
      RegWrite_Out <= 1'b0;
      MemtoReg_Out <= 1'b0;
      AluOut       <= '0;
      ReadData_Out <= '0;
      Rd_out       <= '0;
      mem_err      <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!memop) begin
            valid_out    <= valid_in;
            RegWrite_Out <= valid_in & RegWrite & (Rd_in != 5'd0);
            MemtoReg_Out <= 1'b0;
            AluOut       <= AluResult;
            Rd_out       <= Rd_in;
          end else begin
            // Misaligned or starting an access: MEM/WB gets a bubble either way
            valid_out    <= 1'b0;
            RegWrite_Out <= 1'b0;
            MemtoReg_Out <= 1'b0;
            if (!aligned) begin
              mem_err <= 1'b1;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= MemWrite;
              mem_addr    <= AluResult;
              mem_wdata   <= Datain;
              latRegWrite <= RegWrite;
              latMemtoReg <= MemtoReg;
              latRd       <= Rd_in;
              cnt         <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            valid_out    <= 1'b1;
            RegWrite_Out <= latRegWrite & (latRd != 5'd0);
            MemtoReg_Out <= latMemtoReg;
            AluOut       <= mem_addr;
            Rd_out       <= latRd;
            if (!mem_we) ReadData_Out <= mem_rdata;
          end else begin
            valid_out    <= 1'b0;
            RegWrite_Out <= 1'b0;
            MemtoReg_Out <= 1'b0;
            if (timeoutHit) begin
              mem_req <= 1'b0;
              mem_err <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk, reset;
  logic        valid_in, RegWrite, MemtoReg, MemWrite;
  logic [63:0] AluResult, Datain, mem_rdata;
  logic [4:0]  Rd_in;
  logic        stall, mem_req, mem_we, mem_ack, mem_err;
  logic [63:0] mem_addr, mem_wdata, AluOut, ReadData_Out;
  logic        valid_out, RegWrite_Out, MemtoReg_Out;
  logic [4:0]  Rd_out;

  int tests = 0;
  int fails = 0;

  mem_stage #(.DATA_W(64), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .AluResult(AluResult),
    .Datain(Datain), .Rd_in(Rd_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .valid_out(valid_out),
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out), .AluOut(AluOut),
    .ReadData_Out(ReadData_Out), .Rd_out(Rd_out), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never returns
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic setIn(input logic v, input logic rw, input logic m2r, input logic mw,
                       input logic [63:0] alu, input logic [63:0] din, input logic [4:0] rd);
    valid_in = v; RegWrite = rw; MemtoReg = m2r; MemWrite = mw;
    AluResult = alu; Datain = din; Rd_in = rd;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    repeat (2) @(negedge clk);
    tests++; if ({stall, mem_req, mem_we, valid_out, RegWrite_Out, MemtoReg_Out, mem_err} !== 7'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 0", {stall, mem_req, mem_we, valid_out, RegWrite_Out, MemtoReg_Out, mem_err}); end
    tests++; if ({mem_addr, mem_wdata, AluOut, ReadData_Out, Rd_out} !== '0) begin fails++; $display("FAIL reset_data got nonzero exp 0"); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    setIn(1, 1, 0, 0, 64'h1234, 64'h0, 5'd5);
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL pass_stall got %b exp 0", stall); end
    @(negedge clk);
    tests++; if ({valid_out, RegWrite_Out, MemtoReg_Out} !== 3'b110) begin fails++; $display("FAIL pass_ctrl got %b exp 110", {valid_out, RegWrite_Out, MemtoReg_Out}); end
    tests++; if (AluOut !== 64'h1234 || Rd_out !== 5'd5) begin fails++; $display("FAIL pass_data got %h/%0d exp 1234/5", AluOut, Rd_out); end
    tests++; if (stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL pass_nostall got %b%b exp 00", stall, mem_req); end
    setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
  endtask

  task automatic test_load;
    int stallCycles = 0;
    @(negedge clk);
    setIn(1, 1, 1, 0, 64'h100, 64'h0, 5'd7);
    #1; if (stall) stallCycles++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (stall) stallCycles++;
      if (i == 0) begin
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h100) begin fails++; $display("FAIL load_req got req=%b we=%b addr=%h exp 1/0/100", mem_req, mem_we, mem_addr); end
      end
    end
    tests++; if (stallCycles !== 4) begin fails++; $display("FAIL load_stall_cycles got %0d exp 4", stallCycles); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL load_ack_stall got %b exp 0", stall); end
    @(negedge clk);
    mem_ack = 1'b0; setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    tests++; if (ReadData_Out !== 64'hDEADBEEF) begin fails++; $display("FAIL load_rdata got %h exp deadbeef", ReadData_Out); end
    tests++; if ({valid_out, RegWrite_Out, MemtoReg_Out, mem_req, mem_err} !== 5'b11100) begin fails++; $display("FAIL load_ctrl got %b exp 11100", {valid_out, RegWrite_Out, MemtoReg_Out, mem_req, mem_err}); end
    tests++; if (Rd_out !== 5'd7 || AluOut !== 64'h100) begin fails++; $display("FAIL load_rd got %0d/%h exp 7/100", Rd_out, AluOut); end
  endtask

  task automatic test_store;
    logic sawErr = 1'b0;
    @(negedge clk);
    setIn(1, 0, 0, 1, 64'h208, 64'hCAFE, 5'd0);
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'hCAFE || mem_addr !== 64'h208) begin fails++; $display("FAIL store_req got req=%b we=%b wd=%h a=%h exp 1/1/cafe/208", mem_req, mem_we, mem_wdata, mem_addr); end
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    sawErr = mem_err;
    mem_ack = 1'b0; setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    tests++; if ({valid_out, RegWrite_Out, MemtoReg_Out, sawErr, mem_req} !== 5'b10000) begin fails++; $display("FAIL store_done got %b exp 10000", {valid_out, RegWrite_Out, MemtoReg_Out, sawErr, mem_req}); end
    tests++; if (ReadData_Out !== 64'hDEADBEEF) begin fails++; $display("FAIL store_rdata_hold got %h exp deadbeef", ReadData_Out); end
    // Store carrying RegWrite with a real destination still writes back
    @(negedge clk);
    setIn(1, 1, 0, 1, 64'h300, 64'h55, 5'd9);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    tests++; if ({valid_out, RegWrite_Out} !== 2'b11 || Rd_out !== 5'd9) begin fails++; $display("FAIL store_regwrite got %b/%0d exp 11/9", {valid_out, RegWrite_Out}, Rd_out); end
  endtask

  task automatic test_misaligned;
    @(negedge clk);
    setIn(1, 1, 1, 0, 64'h103, 64'h0, 5'd4);
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mis_stall got %b exp 0", stall); end
    @(negedge clk);
    setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    tests++; if ({mem_req, mem_err, valid_out, RegWrite_Out} !== 4'b0100) begin fails++; $display("FAIL mis_err got %b exp 0100", {mem_req, mem_err, valid_out, RegWrite_Out}); end
    @(negedge clk);
    tests++; if ({mem_req, mem_err} !== 2'b00) begin fails++; $display("FAIL mis_pulse got %b exp 00", {mem_req, mem_err}); end
  endtask

  task automatic test_rd_zero;
    @(negedge clk);
    setIn(1, 1, 1, 0, 64'h40, 64'h0, 5'd0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'h77;
    @(negedge clk);
    mem_ack = 1'b0; setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    tests++; if ({valid_out, RegWrite_Out, MemtoReg_Out} !== 3'b101 || ReadData_Out !== 64'h77) begin fails++; $display("FAIL rd0 got %b/%h exp 101/77", {valid_out, RegWrite_Out, MemtoReg_Out}, ReadData_Out); end
  endtask

  task automatic test_timeout;
    int reqCycles = 0;
    int badStall = 0;
    @(negedge clk);
    setIn(1, 1, 1, 0, 64'h80, 64'h0, 5'd3);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      if (mem_req) reqCycles++;
      if (stall !== (i < 16)) badStall++;
      if (RegWrite_Out !== 1'b0 || mem_err !== 1'b0) badStall++;
    end
    tests++; if (reqCycles !== 16) begin fails++; $display("FAIL to_req_cycles got %0d exp 16", reqCycles); end
    tests++; if (badStall !== 0) begin fails++; $display("FAIL to_stall_profile got %0d bad cycles exp 0", badStall); end
    @(negedge clk);
    setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    tests++; if ({mem_req, mem_err, valid_out, RegWrite_Out} !== 4'b0100) begin fails++; $display("FAIL to_abort got %b exp 0100", {mem_req, mem_err, valid_out, RegWrite_Out}); end
    @(negedge clk);
    tests++; if ({mem_err, valid_out, RegWrite_Out} !== 3'b000) begin fails++; $display("FAIL to_pulse got %b exp 000", {mem_err, valid_out, RegWrite_Out}); end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    setIn(1, 1, 1, 0, 64'h88, 64'h0, 5'd6);
    @(negedge clk);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_pre_req got %b exp 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    tests++; if ({stall, mem_req, valid_out, RegWrite_Out, mem_err} !== 5'b0 || mem_addr !== 64'h0) begin fails++; $display("FAIL rst_mid got %b/%h exp 0", {stall, mem_req, valid_out, RegWrite_Out, mem_err}, mem_addr); end
    @(negedge clk);
    setIn(0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
    reset = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if ({mem_req, valid_out, RegWrite_Out, MemtoReg_Out} !== 4'b0 || ReadData_Out !== 64'h0) begin fails++; $display("FAIL rst_ack_ignored got %b/%h exp 0/0", {mem_req, valid_out, RegWrite_Out, MemtoReg_Out}, ReadData_Out); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_store();
    test_misaligned();
    test_rd_zero();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
